// File: rtl/aes_dma_apb_master.sv
// ---------------------------------------------------------------------------
// aes_dma_apb_master
//
// DMA-side APB2 master placed in front of the AES host interface. Each
// one-cycle request pulse from the host interface becomes one APB transfer:
//   dma_req_wr -> write of one source-stream word into AES_DINR
//   dma_req_rd -> read of one AES_DOUTR word into a 2-entry sink FIFO
// Reads take priority over writes. A read starts only when the sink FIFO can
// hold its result. Every transfer is SETUP, ACCESS, then one IDLE cycle.
//
// Handshakes: a stream word moves on a rising edge where valid and ready are
// both high. A producer holds valid and its data stable until that edge, and
// a consumer may wait on valid before raising ready.
//
// Ports:
//   PCLK, PRESET            clock, synchronous active-high reset
//   dma_en                  enable; low clears the pending counters and
//                           ovf_err, ignores request pulses and lets an
//                           in-progress transfer finish
//   dma_req_wr, dma_req_rd  per-word request pulses from the host interface
//   src_data/valid/ready    source stream (ready only in the write SETUP)
//   snk_data/valid/ready    sink stream, head of the 2-entry FIFO
//   PSEL..PWDATA, PRDATA    APB2 master signals
//   ovf_err                 sticky: a request arrived with its counter full
//   dbg_state               FSM state (IDLE=0, WR_SETUP=1, WR_ACCESS=2,
//                           RD_SETUP=3, RD_ACCESS=4)
//   dbg_pend_wr/rd          pending-request counters
// ---------------------------------------------------------------------------
module aes_dma_apb_master #(
    parameter logic [3:0] DINR_ADDR  = 4'h2,
    parameter logic [3:0] DOUTR_ADDR = 4'h3,
    parameter int         MAX_PEND   = 4
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        dma_en,
    input  logic        dma_req_wr,
    input  logic        dma_req_rd,
    input  logic [31:0] src_data,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [31:0] snk_data,
    output logic        snk_valid,
    input  logic        snk_ready,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [3:0]  PADDR,
    output logic [31:0] PWDATA,
    input  logic [31:0] PRDATA,
    output logic        ovf_err,
    output logic [2:0]  dbg_state,
    output logic [2:0]  dbg_pend_wr,
    output logic [2:0]  dbg_pend_rd
);

    localparam logic [2:0] PEND_MAX = 3'(MAX_PEND);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_SETUP  = 3'd1,
        WR_ACCESS = 3'd2,
        RD_SETUP  = 3'd3,
        RD_ACCESS = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        start_wr;
    logic        start_rd;

    logic [2:0]  pend_wr;
    logic [2:0]  pend_rd;
    logic [3:0]  wr_upd;
    logic [3:0]  rd_upd;

    logic [31:0] buf_mem [2];
    logic        buf_wptr;
    logic        buf_rptr;
    logic [1:0]  buf_cnt;
    logic        buf_push;
    logic        buf_pop;

    // Returns {overflow, next count} for one pending counter.
    function automatic logic [3:0] pend_next(input logic [2:0] cur,
                                             input logic       inc,
                                             input logic       dec);
        logic [3:0] r;
        r = {1'b0, cur};
        if (inc && !dec) begin
            if (cur == PEND_MAX) r = {1'b1, cur};
            else                 r = {1'b0, cur + 3'd1};
        end else if (dec && !inc) begin
            r = {1'b0, cur - 3'd1};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK) begin
        if (PRESET) state <= IDLE;
        else        state <= state_nx;
    end

    // In IDLE no read is in flight (the previous read pushed at the edge
    // leaving RD_ACCESS), so "one free slot counting the in-flight read"
    // reduces to the FIFO not being full.
    always_comb begin
        state_nx = state;
        start_wr = 1'b0;
        start_rd = 1'b0;
        case (state)
            IDLE: begin
                if (dma_en) begin
                    if (pend_rd != 3'd0 && buf_cnt < 2'd2) begin
                        state_nx = RD_SETUP;
                        start_rd = 1'b1;
                    end else if (pend_wr != 3'd0 && src_valid) begin
                        state_nx = WR_SETUP;
                        start_wr = 1'b1;
                    end
                end
            end
            WR_SETUP:  state_nx = WR_ACCESS;
            WR_ACCESS: state_nx = IDLE;
            RD_SETUP:  state_nx = RD_ACCESS;
            RD_ACCESS: state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    // Bus controls decode the state register, so they switch on the edge
    // that enters each phase.
    assign PSEL      = (state != IDLE);
    assign PENABLE   = (state == WR_ACCESS) || (state == RD_ACCESS);
    assign PWRITE    = (state == WR_SETUP) || (state == WR_ACCESS);
    assign src_ready = (state == WR_SETUP);
    assign dbg_state = state;

    // PADDR/PWDATA load on entry to SETUP and hold through ACCESS and the
    // following IDLE. The source holds src_data while valid is high, so the
    // word loaded here is the word consumed during WR_SETUP.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            PADDR  <= 4'h0;
            PWDATA <= 32'h0;
        end else if (start_wr) begin
            PADDR  <= DINR_ADDR;
            PWDATA <= src_data;
        end else if (start_rd) begin
            PADDR  <= DOUTR_ADDR;
        end
    end

    // ------------------------------------------------------------------
    // Pending-request counters
    // ------------------------------------------------------------------
    assign wr_upd = pend_next(pend_wr, dma_req_wr, state == WR_SETUP);
    assign rd_upd = pend_next(pend_rd, dma_req_rd, state == RD_SETUP);

    always_ff @(posedge PCLK) begin
        if (PRESET || !dma_en) begin
            pend_wr <= 3'd0;
            pend_rd <= 3'd0;
            ovf_err <= 1'b0;
        end else begin
            pend_wr <= wr_upd[2:0];
            pend_rd <= rd_upd[2:0];
            if (wr_upd[3] || rd_upd[3]) ovf_err <= 1'b1;
        end
    end

    assign dbg_pend_wr = pend_wr;
    assign dbg_pend_rd = pend_rd;

    // ------------------------------------------------------------------
    // Sink FIFO (2 entries); contents survive dma_en going low
    // ------------------------------------------------------------------
    assign buf_push  = (state == RD_ACCESS);
    assign buf_pop   = snk_valid && snk_ready;
    assign snk_valid = (buf_cnt != 2'd0);
    assign snk_data  = buf_mem[buf_rptr];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            buf_mem[0] <= 32'h0;
            buf_mem[1] <= 32'h0;
            buf_wptr   <= 1'b0;
            buf_rptr   <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            if (buf_push) begin
                buf_mem[buf_wptr] <= PRDATA;
                buf_wptr          <= ~buf_wptr;
            end
            if (buf_pop) buf_rptr <= ~buf_rptr;
            case ({buf_push, buf_pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: buf_cnt <= buf_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_dma_apb_master.sv
// ---------------------------------------------------------------------------
// tb_aes_dma_apb_master
//
// Stimulus (main initial block) pushes expected APB write words as source
// words are queued; the APB slave responder pushes each read word it returns.
// A negedge monitor pops and compares on every APB access and every sink
// handshake, and checks bus phase ordering and pending counts against
// (pulses issued - SETUPs observed).
// ---------------------------------------------------------------------------
module tb_aes_dma_apb_master;

    localparam logic [2:0] ST_IDLE = 3'd0;

    logic        PCLK;
    logic        PRESET;
    logic        dma_en;
    logic        dma_req_wr;
    logic        dma_req_rd;
    logic [31:0] src_data;
    logic        src_valid;
    logic        src_ready;
    logic [31:0] snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [3:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        ovf_err;
    logic [2:0]  dbg_state;
    logic [2:0]  dbg_pend_wr;
    logic [2:0]  dbg_pend_rd;

    aes_dma_apb_master dut (
        .PCLK(PCLK), .PRESET(PRESET), .dma_en(dma_en),
        .dma_req_wr(dma_req_wr), .dma_req_rd(dma_req_rd),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .ovf_err(ovf_err),
        .dbg_state(dbg_state), .dbg_pend_wr(dbg_pend_wr), .dbg_pend_rd(dbg_pend_rd)
    );

    // ---------------- clock ----------------
    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    // ---------------- scoreboard state ----------------
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_wr_q[$];
    logic [31:0] exp_snk_q[$];
    logic [31:0] src_q[$];
    logic [31:0] prdata_q[$];
    logic        order_q[$];
    int          wr_acc_cnt = 0;
    int          rd_acc_cnt = 0;
    int          snk_pop_cnt = 0;
    logic [31:0] last_snk = 32'h0;
    logic        src_rand = 1'b0;
    logic        track_pend = 1'b0;
    int          wr_pulse_m = 0;
    int          wr_setup_m = 0;
    int          rd_pulse_m = 0;
    int          rd_setup_m = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!(exp_wr_q.size() == 0 && exp_snk_q.size() == 0 && dbg_pend_wr == 3'd0 &&
                 dbg_pend_rd == 3'd0 && dbg_state == ST_IDLE && !snk_valid) && n < 300) begin
            tick(1);
            n++;
        end
        check(name, (n < 300) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // ---------------- source driver ----------------
    initial begin
        logic hs;
        src_valid = 1'b0;
        src_data  = 32'h0;
        forever begin
            @(negedge PCLK);
            hs = src_valid && src_ready;
            @(posedge PCLK);
            #1;
            if (hs && src_q.size() > 0) void'(src_q.pop_front());
            if (src_q.size() == 0) begin
                src_valid = 1'b0;
            end else if (hs || !src_valid) begin
                if (!src_rand || $urandom_range(0, 2) != 0) begin
                    src_valid = 1'b1;
                    src_data  = src_q[0];
                end else begin
                    src_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor + APB slave responder ----------------
    initial begin
        logic        prev_psel;
        logic        prev_pen;
        logic [31:0] d;
        prev_psel = 1'b0;
        prev_pen  = 1'b0;
        PRDATA    = 32'h0;
        forever begin
            @(negedge PCLK);
            if (track_pend) begin
                check("pend_wr_model", {29'b0, dbg_pend_wr}, wr_pulse_m - wr_setup_m);
                check("pend_rd_model", {29'b0, dbg_pend_rd}, rd_pulse_m - rd_setup_m);
                if (dma_req_wr) wr_pulse_m++;
                if (dma_req_rd) rd_pulse_m++;
                if (PSEL && !PENABLE && PWRITE)  wr_setup_m++;
                if (PSEL && !PENABLE && !PWRITE) rd_setup_m++;
            end
            if (PSEL && !PENABLE) begin
                check("setup_after_idle", {31'b0, prev_psel}, 32'd0);
                order_q.push_back(PWRITE);
                if (!PWRITE) begin
                    check("rd_setup_addr", {28'b0, PADDR}, 32'h3);
                    if (prdata_q.size() > 0) d = prdata_q.pop_front();
                    else                     d = $urandom;
                    PRDATA = d;
                    exp_snk_q.push_back(d);
                    check("snk_no_overflow", (exp_snk_q.size() <= 2) ? 32'd1 : 32'd0, 32'd1);
                end else begin
                    check("wr_setup_addr", {28'b0, PADDR}, 32'h2);
                end
            end
            if (PSEL && PENABLE) begin
                check("access_after_setup", (prev_psel && !prev_pen) ? 32'd1 : 32'd0, 32'd1);
                if (PWRITE) begin
                    wr_acc_cnt++;
                    check("wr_addr", {28'b0, PADDR}, 32'h2);
                    if (exp_wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
                    else                      check("wr_data", PWDATA, exp_wr_q.pop_front());
                end else begin
                    rd_acc_cnt++;
                    check("rd_addr", {28'b0, PADDR}, 32'h3);
                end
            end
            if (src_ready || (PSEL && !PENABLE && PWRITE))
                check("src_ready_phase", {31'b0, src_ready},
                      (PSEL && !PENABLE && PWRITE) ? 32'd1 : 32'd0);
            if (snk_valid && snk_ready) begin
                snk_pop_cnt++;
                last_snk = snk_data;
                if (exp_snk_q.size() == 0) check("snk_unexpected", 32'd1, 32'd0);
                else                       check("snk_data", snk_data, exp_snk_q.pop_front());
            end
            prev_psel = PSEL;
            prev_pen  = PENABLE;
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          base_wr;
        int          base_rd;
        int          n;
        int          nwr;
        int          nrd;
        logic [31:0] w;

        PRESET = 1'b1; dma_en = 1'b0; dma_req_wr = 1'b0; dma_req_rd = 1'b0; snk_ready = 1'b0;
        tick(3);
        check("rst_state",   {29'b0, dbg_state}, 32'd0);
        check("rst_pend_wr", {29'b0, dbg_pend_wr}, 32'd0);
        check("rst_pend_rd", {29'b0, dbg_pend_rd}, 32'd0);
        check("rst_ctrl", {26'b0, PSEL, PENABLE, PWRITE, src_ready, snk_valid, ovf_err}, 32'd0);
        check("rst_paddr",   {28'b0, PADDR}, 32'd0);
        check("rst_pwdata",  PWDATA, 32'd0);
        check("rst_snk_data", snk_data, 32'd0);
        PRESET = 1'b0;
        dma_en = 1'b1;
        tick(1);

        // 4 writes, pulses 3 cycles apart, source always valid
        for (int i = 0; i < 4; i++) begin
            w = 32'h11111111 * (i + 1);
            src_q.push_back(w);
            exp_wr_q.push_back(w);
        end
        base_wr = wr_acc_cnt;
        tick(2);
        for (int i = 0; i < 4; i++) begin
            dma_req_wr = 1'b1; tick(1); dma_req_wr = 1'b0; tick(2);
        end
        wait_done("t1_done");
        check("t1_writes", wr_acc_cnt - base_wr, 32'd4);
        check("t1_pend_wr", {29'b0, dbg_pend_wr}, 32'd0);

        // two reads with fixed PRDATA, sink always ready
        snk_ready = 1'b1;
        prdata_q.push_back(32'hCAFE0001);
        prdata_q.push_back(32'hCAFE0002);
        base_rd = rd_acc_cnt;
        n = snk_pop_cnt;
        dma_req_rd = 1'b1; tick(2); dma_req_rd = 1'b0;
        wait_done("t2_done");
        check("t2_reads", rd_acc_cnt - base_rd, 32'd2);
        check("t2_pops", snk_pop_cnt - n, 32'd2);
        check("t2_last_word", last_snk, 32'hCAFE0002);

        // sink stalled: only two reads fit, then resume
        snk_ready = 1'b0;
        base_rd = rd_acc_cnt;
        dma_req_rd = 1'b1; tick(4); dma_req_rd = 1'b0;
        tick(20);
        check("t3_stall_reads", rd_acc_cnt - base_rd, 32'd2);
        check("t3_stall_pend_rd", {29'b0, dbg_pend_rd}, 32'd2);
        check("t3_stall_state", {29'b0, dbg_state}, 32'd0);
        check("t3_stall_snk_valid", {31'b0, snk_valid}, 32'd1);
        snk_ready = 1'b1;
        wait_done("t3_done");
        check("t3_reads", rd_acc_cnt - base_rd, 32'd4);
        check("t3_no_ovf", {31'b0, ovf_err}, 32'd0);

        // simultaneous requests: read goes first
        w = 32'hA5A5_0001;
        src_q.push_back(w);
        exp_wr_q.push_back(w);
        tick(2);
        order_q.delete();
        dma_req_wr = 1'b1; dma_req_rd = 1'b1; tick(1); dma_req_wr = 1'b0; dma_req_rd = 1'b0;
        wait_done("t4_done");
        check("t4_count", order_q.size(), 32'd2);
        if (order_q.size() == 2) begin
            check("t4_first_is_read", {31'b0, order_q[0]}, 32'd0);
            check("t4_second_is_write", {31'b0, order_q[1]}, 32'd1);
        end

        // overflow with source idle, cleared by a one-cycle dma_en drop
        dma_req_wr = 1'b1; tick(4); dma_req_wr = 1'b0;
        check("t5_pend_at_max", {29'b0, dbg_pend_wr}, 32'd4);
        check("t5_no_ovf_yet", {31'b0, ovf_err}, 32'd0);
        dma_req_wr = 1'b1; tick(1); dma_req_wr = 1'b0;
        check("t5_pend_held", {29'b0, dbg_pend_wr}, 32'd4);
        check("t5_ovf_set", {31'b0, ovf_err}, 32'd1);
        check("t5_idle", {29'b0, dbg_state}, 32'd0);
        dma_en = 1'b0; tick(1); dma_en = 1'b1;
        check("t5_pend_cleared", {29'b0, dbg_pend_wr}, 32'd0);
        check("t5_ovf_cleared", {31'b0, ovf_err}, 32'd0);

        // dma_en low mid-write: access completes, pulses ignored, sink kept
        snk_ready = 1'b0;
        prdata_q.push_back(32'h5A5A0001);
        dma_req_rd = 1'b1; tick(1); dma_req_rd = 1'b0;
        tick(6);
        check("t6_snk_loaded", {31'b0, snk_valid}, 32'd1);
        w = 32'hBEEF0042;
        src_q.push_back(w);
        exp_wr_q.push_back(w);
        tick(2);
        base_rd = rd_acc_cnt;
        dma_req_wr = 1'b1; tick(1); dma_req_wr = 1'b0;
        n = 0;
        while (!(PSEL && !PENABLE) && n < 10) begin tick(1); n++; end
        check("t6_setup_seen", (n < 10) ? 32'd1 : 32'd0, 32'd1);
        dma_en = 1'b0;
        dma_req_rd = 1'b1; tick(1); dma_req_rd = 1'b0;
        check("t6_access_completes", {30'b0, PSEL, PENABLE}, 32'd3);
        tick(1);
        check("t6_idle_after", {29'b0, dbg_state}, 32'd0);
        tick(3);
        dma_en = 1'b1;
        tick(5);
        check("t6_pulse_ignored_reads", rd_acc_cnt - base_rd, 32'd0);
        check("t6_pend_rd", {29'b0, dbg_pend_rd}, 32'd0);
        check("t6_write_done", exp_wr_q.size(), 32'd0);
        check("t6_snk_kept_valid", {31'b0, snk_valid}, 32'd1);
        check("t6_snk_kept_data", snk_data, 32'h5A5A0001);
        snk_ready = 1'b1;
        wait_done("t6_done");

        // reset during WR_ACCESS
        for (int i = 0; i < 3; i++) begin
            w = 32'h7000_0000 + i;
            src_q.push_back(w);
            exp_wr_q.push_back(w);
        end
        tick(2);
        dma_req_wr = 1'b1; tick(3); dma_req_wr = 1'b0;
        n = 0;
        while (!(PSEL && PENABLE && PWRITE) && n < 10) begin tick(1); n++; end
        check("t7_access_seen", (n < 10) ? 32'd1 : 32'd0, 32'd1);
        PRESET = 1'b1;
        tick(1);
        check("t7_psel", {31'b0, PSEL}, 32'd0);
        check("t7_penable", {31'b0, PENABLE}, 32'd0);
        check("t7_src_ready", {31'b0, src_ready}, 32'd0);
        check("t7_pend", {26'b0, dbg_pend_wr, dbg_pend_rd}, 32'd0);
        PRESET = 1'b0;
        src_q.delete();
        exp_wr_q.delete();
        tick(3);
        check("t7_quiet", {30'b0, PSEL, src_valid}, 32'd0);

        // randomized traffic
        wr_pulse_m = 0; wr_setup_m = 0; rd_pulse_m = 0; rd_setup_m = 0;
        track_pend = 1'b1;
        src_rand = 1'b1;
        base_wr = wr_acc_cnt;
        base_rd = rd_acc_cnt;
        nwr = 0;
        nrd = 0;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0 && (wr_pulse_m - wr_setup_m) <= 2) begin
                w = $urandom;
                src_q.push_back(w);
                exp_wr_q.push_back(w);
                dma_req_wr = 1'b1;
                nwr++;
            end else begin
                dma_req_wr = 1'b0;
            end
            if ($urandom_range(0, 3) == 0 && (rd_pulse_m - rd_setup_m) <= 2) begin
                dma_req_rd = 1'b1;
                nrd++;
            end else begin
                dma_req_rd = 1'b0;
            end
            snk_ready = ($urandom_range(0, 2) != 0);
            tick(1);
        end
        dma_req_wr = 1'b0;
        dma_req_rd = 1'b0;
        snk_ready = 1'b1;
        wait_done("rand_done");
        track_pend = 1'b0;
        check("rand_writes", wr_acc_cnt - base_wr, nwr);
        check("rand_reads", rd_acc_cnt - base_rd, nrd);
        check("rand_no_ovf", {31'b0, ovf_err}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_dma_apb_master.md
Name: aes_dma_apb_master

Overview:
- DMA-side APB master that sits directly upstream of the AES host interface on its APB slave port.
- It turns the host interface's per-word DMA request pulses (dma_req_wr, dma_req_rd) into APB2 transfers:
  - writes words from a source stream into AES_DINR;
  - reads words from AES_DOUTR into a sink stream.
- The block owns the APB bus to the host interface whenever it is enabled.

Parameters:
- DINR_ADDR, 4'h2, PADDR value of AES_DINR
- DOUTR_ADDR, 4'h3, PADDR value of AES_DOUTR
- MAX_PEND, 4, saturation limit of each pending-request counter (words per block)

Ports:
- PCLK  in  1  clock
- PRESET  in  1  synchronous active-high reset
- dma_en  in  1  block enable; low = flush and idle
- dma_req_wr  in  1  one-cycle pulse: host interface wants one DINR word
- dma_req_rd  in  1  one-cycle pulse: one DOUTR word is available
- src_data  in  32  source stream word
- src_valid  in  1  source word valid
- src_ready  out  1  source word consumed this cycle
- snk_data  out  32  sink stream word
- snk_valid  out  1  sink word valid
- snk_ready  in  1  sink accepts word
- PSEL  out  1  APB select
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PADDR  out  4  APB address
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data (slave registers it; valid in access phase)
- ovf_err  out  1  sticky: a request pulse arrived with its counter at MAX_PEND

Behaviour:
Reset:
- PRESET is sampled on the PCLK rising edge.
- After reset:
  - state IDLE;
  - pend_wr = pend_rd = 0;
  - PSEL, PENABLE, PWRITE, src_ready, snk_valid, ovf_err all 0;
  - PADDR = 0, PWDATA = 0, snk_data = 0;
  - sink buffer empty.
- Reset mid-transfer aborts immediately; no partial APB phase is held.

Pending counters:
- pend_wr and pend_rd are 3-bit, range 0..MAX_PEND.
- A req pulse increments its counter. Issuing the SETUP phase of the matching transfer decrements it.
- A pulse and a decrement in the same cycle leave the counter unchanged.
- A pulse arriving at MAX_PEND with no decrement that cycle:
  - the counter holds;
  - ovf_err is set to 1 (sticky until reset or until dma_en goes low).

Sink buffer:
- 2-entry FIFO feeding snk_data/snk_valid.
- snk_data is the head entry; snk_valid = not empty.
- An entry pops when snk_valid & snk_ready.
- A push and a pop in the same cycle are both honoured.

FSM states: IDLE, WR_SETUP, WR_ACCESS, RD_SETUP, RD_ACCESS.
- IDLE:
  - read has priority: if pend_rd>0 and buffer free slots minus in-flight reads >= 1 -> RD_SETUP;
  - else if pend_wr>0 and src_valid -> WR_SETUP;
  - else stay in IDLE.
- WR_SETUP:
  - PSEL=1, PENABLE=0, PWRITE=1, PADDR=DINR_ADDR, PWDATA=src_data;
  - src_ready=1 for exactly this cycle;
  - pend_wr decrements;
  - next state WR_ACCESS.
- WR_ACCESS:
  - PSEL=1, PENABLE=1; PWDATA and PADDR held;
  - next state IDLE.
- RD_SETUP:
  - PSEL=1, PENABLE=0, PWRITE=0, PADDR=DOUTR_ADDR;
  - pend_rd decrements;
  - next state RD_ACCESS.
- RD_ACCESS:
  - PSEL=1, PENABLE=1;
  - PRDATA is pushed into the sink buffer at the closing edge;
  - next state IDLE.
- Outputs are registered: PSEL/PENABLE change on the state-entry edge.
- Back-to-back transfers are separated by one IDLE cycle, so each transfer takes 3 cycles.

Other rules:
- PSEL is low in IDLE. PADDR and PWDATA hold their last value in IDLE.
- A read is never issued when the sink buffer could overflow: a read starts only with at least one free slot, counting the in-flight read.
- dma_en low:
  - any transfer in progress completes its ACCESS phase, then the FSM goes to IDLE;
  - pend_wr, pend_rd and ovf_err clear;
  - request pulses are ignored;
  - the sink buffer keeps its data.
- src_ready is never asserted outside WR_SETUP.

Test Plan:
- Reset, then 4 dma_req_wr pulses spaced 3 cycles apart, src words 0x11111111..0x44444444 always valid -> 4 APB writes to PADDR=2 with PWDATA in order; PSEL high 2 cycles each; pend_wr ends at 0.
- pend_rd=2 with PRDATA returning 0xCAFE0001 then 0xCAFE0002, snk_ready=1 -> snk_data shows both words in order; APB reads use PADDR=3, PWRITE=0.
- snk_ready=0 and 4 dma_req_rd pulses -> exactly 2 reads issued, then the FSM stalls in IDLE with pend_rd=2; raising snk_ready resumes the remaining 2 reads.
- pend_wr=1 and pend_rd=1 set in the same cycle -> the read is issued first, then the write.
- 5 dma_req_wr pulses with src_valid=0 -> pend_wr=4 and ovf_err=1; dropping dma_en for 1 cycle clears both.
- PRESET asserted during WR_ACCESS -> next cycle PSEL=0, PENABLE=0, src_ready=0, counters 0.
